tx_data_fifo: RTL
=================

// Module: tx_data_fifo
// PURPOSE
//  Byte FIFO between the SD card read path and the USB transmitter.
//  - Write side: the SD controller pushes bytes as it reads them.
//  - Read side: first-word-fall-through. The head byte drives the transmitter's sd_data input.
//  - The transmitter pops one byte per load_enable_sd pulse. It samples empty to decide end of payload.
// PARAMETERS
//  DEPTH    16  number of byte entries; power of two, >= 4
//  ADDR_W   4   log2(DEPTH); ptr/count widths derive from it
// PORTS
//  clk           in   1       system clock; all state on rising edge
//  n_rst         in   1       asynchronous reset, active-low
//  clear         in   1       synchronous flush; highest priority after reset
//  w_enable      in   1       push w_data this cycle
//  w_data        in   8       byte from SD read path
//  r_enable      in   1       pop head byte (connected to transmitter load_enable_sd)
//  r_data        out  8       head byte (connected to transmitter sd_data)
//  empty         out  1       no bytes stored
//  full          out  1       DEPTH bytes stored
//  count         out  ADDR_W+1  bytes stored, 0..DEPTH
//  overflow      out  1       sticky: push attempted while full and no pop
//  underflow     out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (n_rst=0, async)
//   - wr_ptr=rd_ptr=0, count=0, empty=1, full=0.
//   - overflow=0, underflow=0, r_data=8'h00.
//   - Memory contents are not reset.
//  Pointers
//   - ADDR_W+1 bits; the low ADDR_W bits index memory.
//   - Wrap naturally at 2*DEPTH.
//   - empty = (wr_ptr==rd_ptr).
//   - full = (addr bits equal, MSBs differ).
//   - count = wr_ptr-rd_ptr, modulo 2^(ADDR_W+1).
//  Read path (FWFT)
//   - r_data = mem[rd_ptr[ADDR_W-1:0]] combinationally when !empty; 8'h00 when empty.
//   - Zero read latency: the byte is valid the same cycle empty deasserts.
//  Write latency
//   - A byte pushed in cycle N is visible on r_data, with empty=0, in cycle N+1.
//  Accepted operations per cycle (clear=0)
//   - push accepted iff w_enable && (!full || r_enable).
//   - pop accepted iff r_enable && !empty.
//  Boundary conditions
//   - Full + push + pop: both accepted, count unchanged, wr_ptr and rd_ptr both advance.
//   - Empty + push + pop: push accepted, pop rejected, underflow set, count becomes 1.
//   - Full + push, no pop: byte dropped, state unchanged, overflow set.
//   - Empty + pop, no push: no state change, underflow set.
//  Flags
//   - overflow/underflow stay set until clear or reset.
//  clear=1
//   - Next edge: pointers=0, count=0, flags=0.
//   - w_enable/r_enable ignored that cycle.
//  Reset mid-operation
//   - Immediate return to reset values; no partial byte is exposed.
// CONFIGURATION
//  TX_FIFO_WATERMARK_EN defined
//   - Adds output almost_full (1) = (count >= DEPTH-2), combinational from count.
//   - Lets the SD read path throttle before full.
//   - almost_full resets to 0.
//  TX_FIFO_WATERMARK_EN undefined
//   - almost_full port and its logic are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  Package usb_tx_pkg holds:
//   - typedef logic [7:0] byte_t
//   - localparam TX_FIFO_DEPTH=16 and TX_FIFO_ADDR_W=4
//   - localparam byte_t TX_FIFO_EMPTY_DATA=8'h00
//  Sub-module tx_fifo_mem: DEPTH x byte_t register file.
//   - One synchronous write port (we, waddr, wdata).
//   - One combinational read port (raddr, rdata).
//   - No reset.
//  tx_data_fifo itself holds pointers, flags, accept logic and the FWFT output mux.
// TESTING
//  1. Reset, push 8'hA5 then 8'h3C, no pops
//     -> cycle after first push: r_data=A5, empty=0, count=1.
//     -> after second push: count=2, r_data still A5.
//  2. Fill with bytes 0x00..0x0F
//     -> full=1, count=16.
//     -> 17th push 0xFF: dropped, overflow=1.
//     -> then 16 pops yield 0x00..0x0F in order, then empty=1, r_data=00.
//  3. Full, push 0x77 + pop together
//     -> count stays 16, r_data advances to the next byte.
//     -> 0x77 is the last byte read out.
//  4. Empty, push 0x5A + pop together
//     -> underflow=1, count=1, r_data=5A.
//  5. Wrap: push/pop 40 bytes with occupancy held at 3
//     -> data order preserved across 2*DEPTH pointer wrap.
//     -> count never exceeds 3.
//  6. clear while count=5 and overflow=1
//     -> next cycle count=0, empty=1, overflow=0.
//     -> n_rst pulse mid-stream gives the same result asynchronously.
//     -> with TX_FIFO_WATERMARK_EN: almost_full=1 at count 14 and 0 at count 13.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and sizing for the SD-to-USB transmit data path.
package usb_tx_pkg;

    typedef logic [7:0] byte_t;

    localparam int    TX_FIFO_DEPTH      = 16;
    localparam int    TX_FIFO_ADDR_W     = 4;
    localparam byte_t TX_FIFO_EMPTY_DATA = 8'h00;

endpackage : usb_tx_pkg

// File: rtl/tx_fifo_mem.sv
// DEPTH x byte register file: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; validity is tracked by the FIFO pointers.
module tx_fifo_mem
    import usb_tx_pkg::*;
#(
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int ADDR_W = TX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : tx_fifo_mem

// File: rtl/tx_data_fifo.sv
// First-word-fall-through byte FIFO from the SD read path to the USB transmitter.
// Optional TX_FIFO_WATERMARK_EN adds an almost_full output (count >= DEPTH-2).
module tx_data_fifo
    import usb_tx_pkg::*;
#(
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int ADDR_W = TX_FIFO_ADDR_W
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            w_enable,
    input  byte_t           w_data,
    input  logic            r_enable,
    output byte_t           r_data,
    output logic            empty,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            underflow
`ifdef TX_FIFO_WATERMARK_EN
    ,
    output logic            almost_full
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            push_s, pop_s;
    byte_t           mem_rdata_s;

    // Extra pointer MSB distinguishes full from empty when the address bits match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop
    assign push_s = w_enable && (!full || r_enable);
    assign pop_s  = r_enable && !empty;

    // Next-state for pointers and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = PTR_ZERO;
            rd_ptr_d    = PTR_ZERO;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (w_enable && full && !r_enable) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            if (r_enable && empty) begin
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    tx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_s && !clear),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata_s)
    );

    // Unreset memory is masked while empty so stale bytes never reach the transmitter
    assign r_data    = empty ? TX_FIFO_EMPTY_DATA : mem_rdata_s;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef TX_FIFO_WATERMARK_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(DEPTH - 2);
    assign almost_full = (count >= AF_LEVEL);
`endif

endmodule : tx_data_fifo
